// File: rtl/window_addr_iterator.sv
// Sliding-window read-address generator for channel-planar feature maps. It walks
// the loops ch/oy/ox/ky/kx and emits one SRAM address per handshake, with window framing flags.
module window_addr_iterator #(
    parameter int CHANNELS     = 5,
    parameter int KERNEL_SIZEX = 2,
    parameter int KERNEL_SIZEY = 2,
    parameter int STRIDE_X     = 2,
    parameter int STRIDE_Y     = 2,
    parameter int INPUT_WIDTH  = 28,
    parameter int INPUT_HEIGHT = 28,
    parameter int ADDR_W       = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              go,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] aa_data,
    output logic              cena,
    output logic              first_data,
    output logic              last_data,
    output logic              plane_last,
    output logic              busy,
    output logic              ready
);
    localparam int SX_SAFE = (STRIDE_X > 0) ? STRIDE_X : 1;
    localparam int SY_SAFE = (STRIDE_Y > 0) ? STRIDE_Y : 1;
    localparam int OUT_W   = (INPUT_WIDTH >= KERNEL_SIZEX)  ? (INPUT_WIDTH - KERNEL_SIZEX) / SX_SAFE + 1 : 1;
    localparam int OUT_H   = (INPUT_HEIGHT >= KERNEL_SIZEY) ? (INPUT_HEIGHT - KERNEL_SIZEY) / SY_SAFE + 1 : 1;

    localparam int KXW = (KERNEL_SIZEX > 1) ? $clog2(KERNEL_SIZEX) : 1;
    localparam int KYW = (KERNEL_SIZEY > 1) ? $clog2(KERNEL_SIZEY) : 1;
    localparam int OXW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int OYW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [KXW-1:0] KX_MAX = KXW'(KERNEL_SIZEX - 1);
    localparam logic [KYW-1:0] KY_MAX = KYW'(KERNEL_SIZEY - 1);
    localparam logic [OXW-1:0] OX_MAX = OXW'(OUT_W - 1);
    localparam logic [OYW-1:0] OY_MAX = OYW'(OUT_H - 1);
    localparam logic [CHW-1:0] CH_MAX = CHW'(CHANNELS - 1);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(INPUT_WIDTH);
    localparam logic [ADDR_W-1:0] OX_STEP  = ADDR_W'(STRIDE_X);
    localparam logic [ADDR_W-1:0] OY_STEP  = ADDR_W'(STRIDE_Y * INPUT_WIDTH);
    localparam logic [ADDR_W-1:0] CH_STEP  = ADDR_W'(INPUT_WIDTH * INPUT_HEIGHT);

    localparam longint MAP_WORDS  = longint'(CHANNELS) * longint'(INPUT_WIDTH) * longint'(INPUT_HEIGHT);
    localparam longint ADDR_SPACE = longint'(1) << ADDR_W;

    if (INPUT_WIDTH < KERNEL_SIZEX || INPUT_HEIGHT < KERNEL_SIZEY ||
        STRIDE_X == 0 || STRIDE_Y == 0 || MAP_WORDS > ADDR_SPACE) begin : g_param_check
        $error("window_addr_iterator: illegal parameter combination");
    end

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] aa_q, aa_d;
    logic              first_q, first_d, last_q, last_d, plane_last_q, plane_last_d;

    logic [KXW-1:0] kx_q, kx_d, kx_a;
    logic [KYW-1:0] ky_q, ky_d, ky_a;
    logic [OXW-1:0] ox_q, ox_d, ox_a;
    logic [OYW-1:0] oy_q, oy_d, oy_a;
    logic [CHW-1:0] ch_q, ch_d, ch_a;
    // Per-loop address contributions, stepped by constants instead of multiplied per beat.
    logic [ADDR_W-1:0] ky_off_q, ky_off_d, ky_off_a;
    logic [ADDR_W-1:0] ox_off_q, ox_off_d, ox_off_a;
    logic [ADDR_W-1:0] oy_off_q, oy_off_d, oy_off_a;
    logic [ADDR_W-1:0] ch_off_q, ch_off_d, ch_off_a;

    logic handshake, final_beat, step, clear;

    assign handshake  = valid_q & out_ready;
    assign final_beat = (kx_q == KX_MAX) && (ky_q == KY_MAX) && (ox_q == OX_MAX) &&
                        (oy_q == OY_MAX) && (ch_q == CH_MAX);

    always_comb begin
        kx_a = kx_q;  ky_a = ky_q;  ox_a = ox_q;  oy_a = oy_q;  ch_a = ch_q;
        ky_off_a = ky_off_q;  ox_off_a = ox_off_q;
        oy_off_a = oy_off_q;  ch_off_a = ch_off_q;
        if (kx_q != KX_MAX) begin
            kx_a = kx_q + KXW'(1);
        end else begin
            kx_a = '0;
            if (ky_q != KY_MAX) begin
                ky_a     = ky_q + KYW'(1);
                ky_off_a = ky_off_q + ROW_STEP;
            end else begin
                ky_a     = '0;
                ky_off_a = '0;
                if (ox_q != OX_MAX) begin
                    ox_a     = ox_q + OXW'(1);
                    ox_off_a = ox_off_q + OX_STEP;
                end else begin
                    ox_a     = '0;
                    ox_off_a = '0;
                    if (oy_q != OY_MAX) begin
                        oy_a     = oy_q + OYW'(1);
                        oy_off_a = oy_off_q + OY_STEP;
                    end else begin
                        oy_a     = '0;
                        oy_off_a = '0;
                        ch_a     = ch_q + CHW'(1);
                        ch_off_a = ch_off_q + CH_STEP;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        ready_d = 1'b0;
        step    = 1'b0;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go && !abort) begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    clear   = 1'b1;
                end
            end
            ST_RUN: begin
                // abort takes priority over a handshake in the same cycle
                if (abort) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    clear   = 1'b1;
                end else if (handshake) begin
                    if (final_beat) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        ready_d = 1'b1;
                        clear   = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                clear   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                clear   = 1'b1;
            end
        endcase
    end

    always_comb begin
        kx_d = kx_q;  ky_d = ky_q;  ox_d = ox_q;  oy_d = oy_q;  ch_d = ch_q;
        ky_off_d = ky_off_q;  ox_off_d = ox_off_q;
        oy_off_d = oy_off_q;  ch_off_d = ch_off_q;
        if (step) begin
            kx_d = kx_a;  ky_d = ky_a;  ox_d = ox_a;  oy_d = oy_a;  ch_d = ch_a;
            ky_off_d = ky_off_a;  ox_off_d = ox_off_a;
            oy_off_d = oy_off_a;  ch_off_d = ch_off_a;
        end else if (clear) begin
            kx_d = '0;  ky_d = '0;  ox_d = '0;  oy_d = '0;  ch_d = '0;
            ky_off_d = '0;  ox_off_d = '0;  oy_off_d = '0;  ch_off_d = '0;
        end
        aa_d         = ch_off_d + oy_off_d + ky_off_d + ox_off_d + ADDR_W'(kx_d);
        first_d      = valid_d && (kx_d == '0) && (ky_d == '0);
        last_d       = valid_d && (kx_d == KX_MAX) && (ky_d == KY_MAX);
        plane_last_d = last_d && (ox_d == OX_MAX) && (oy_d == OY_MAX);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            aa_q         <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            plane_last_q <= 1'b0;
            kx_q         <= '0;
            ky_q         <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            ch_q         <= '0;
            ky_off_q     <= '0;
            ox_off_q     <= '0;
            oy_off_q     <= '0;
            ch_off_q     <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            aa_q         <= aa_d;
            first_q      <= first_d;
            last_q       <= last_d;
            plane_last_q <= plane_last_d;
            kx_q         <= kx_d;
            ky_q         <= ky_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            ch_q         <= ch_d;
            ky_off_q     <= ky_off_d;
            ox_off_q     <= ox_off_d;
            oy_off_q     <= oy_off_d;
            ch_off_q     <= ch_off_d;
        end
    end

    assign out_valid  = valid_q;
    assign aa_data    = aa_q;
    assign cena       = ~(valid_q & out_ready);
    assign first_data = first_q;
    assign last_data  = last_q;
    assign plane_last = plane_last_q;
    assign busy       = busy_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_window_addr_iterator.sv
// Bench for window_addr_iterator. The expected beats come from an index-decomposition
// model, and the bench drives two configurations: non-overlapping 2x2/s2 and overlapping 3x3/s1.
module tb_window_addr_iterator;

    typedef struct { int c; int kx; int ky; int sx; int sy; int w; int h; } cfg_t;
    typedef struct { int addr; bit f; bit l; bit p; } beat_t;

    logic clk = 1'b0;
    logic rstn, go, abort, out_ready;
    logic out_valid, cena, first_data, last_data, plane_last, busy, ready;
    logic [11:0] aa_data;
    logic go_b, abort_b, ready_in_b;
    logic out_valid_b, cena_b, first_b, last_b, plane_last_b, busy_b, ready_b;
    logic [11:0] aa_data_b;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    cfg_t cfg_a, cfg_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    window_addr_iterator #(
        .CHANNELS(2), .KERNEL_SIZEX(2), .KERNEL_SIZEY(2), .STRIDE_X(2), .STRIDE_Y(2),
        .INPUT_WIDTH(4), .INPUT_HEIGHT(4), .ADDR_W(12)
    ) u_dut (
        .clk(clk), .rstn(rstn), .go(go), .abort(abort), .out_ready(out_ready),
        .out_valid(out_valid), .aa_data(aa_data), .cena(cena), .first_data(first_data),
        .last_data(last_data), .plane_last(plane_last), .busy(busy), .ready(ready)
    );

    window_addr_iterator #(
        .CHANNELS(1), .KERNEL_SIZEX(3), .KERNEL_SIZEY(3), .STRIDE_X(1), .STRIDE_Y(1),
        .INPUT_WIDTH(5), .INPUT_HEIGHT(5), .ADDR_W(12)
    ) u_dut_b (
        .clk(clk), .rstn(rstn), .go(go_b), .abort(abort_b), .out_ready(ready_in_b),
        .out_valid(out_valid_b), .aa_data(aa_data_b), .cena(cena_b), .first_data(first_b),
        .last_data(last_b), .plane_last(plane_last_b), .busy(busy_b), .ready(ready_b)
    );

    function automatic int out_dim(input int in_sz, input int k, input int s);
        return (in_sz - k) / s + 1;
    endfunction

    function automatic int n_beats(input cfg_t cf);
        return cf.c * out_dim(cf.h, cf.ky, cf.sy) * out_dim(cf.w, cf.kx, cf.sx) * cf.ky * cf.kx;
    endfunction

    // Beat k decomposed with kx innermost, then ky, ox, oy, ch.
    function automatic beat_t model_beat(input cfg_t cf, input int k);
        beat_t b;
        int ow, oh, r, kx, ky, ox, oy, ch;
        ow = out_dim(cf.w, cf.kx, cf.sx);
        oh = out_dim(cf.h, cf.ky, cf.sy);
        r  = k;
        kx = r % cf.kx;  r = r / cf.kx;
        ky = r % cf.ky;  r = r / cf.ky;
        ox = r % ow;     r = r / ow;
        oy = r % oh;     ch = r / oh;
        b.addr = (ch * cf.w * cf.h + (oy * cf.sy + ky) * cf.w + ox * cf.sx + kx) % 4096;
        b.f = (kx == 0) && (ky == 0);
        b.l = (kx == cf.kx - 1) && (ky == cf.ky - 1);
        b.p = b.l && (ox == ow - 1) && (oy == oh - 1);
        return b;
    endfunction

    // mode 0: always ready, 1: 3-cycle stall on beat 4, 2: random ready
    task automatic run_walk(input string name, input int mode, input int abort_at, input bit go_mid);
        int n_exp, idx, stalls, c0, post_abort, stall_done;
        bit final_prev, abort_prev, ready_prev, aborted, done, go_sent, hs;
        beat_t b;
        n_exp = n_beats(cfg_a);
        idx = 0; stalls = 0; post_abort = 0; stall_done = 0;
        final_prev = 0; abort_prev = 0; ready_prev = 0; aborted = 0; done = 0; go_sent = 0;
        @(posedge clk); #1;
        go = 1'b1; out_ready = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        go = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            case (mode)
                1:       out_ready = !(idx == 4 && stall_done < 3);
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
            if (mode == 1 && !out_ready) stall_done++;
            abort = (idx == abort_at) && out_valid && !aborted;
            if (abort) aborted = 1;
            go = go_mid && (idx == 7) && !go_sent;
            if (go) go_sent = 1;
            @(negedge clk);
            checks++;
            if (cena !== ~(out_valid & out_ready))
                $display("FAIL %s cena: got %b expected %b", name, cena, ~(out_valid & out_ready));
            if (n == 0) begin
                checks++;
                if ({out_valid, busy} !== 2'b11) begin
                    fails++;
                    $display("FAIL %s start_latency: valid/busy got %b%b expected 11", name, out_valid, busy);
                end
            end
            if (out_valid) begin
                if (idx >= n_exp) begin
                    checks++; fails++;
                    $display("FAIL %s overrun: beat %0d valid, expected only %0d beats", name, idx, n_exp);
                end else begin
                    b = model_beat(cfg_a, idx);
                    checks++;
                    if (aa_data !== 12'(b.addr)) begin
                        fails++;
                        $display("FAIL %s addr beat %0d: got %0d expected %0d", name, idx, aa_data, b.addr);
                    end
                    checks++;
                    if ({first_data, last_data, plane_last} !== {b.f, b.l, b.p}) begin
                        fails++;
                        $display("FAIL %s flags beat %0d: got %b%b%b expected %b%b%b", name, idx,
                                 first_data, last_data, plane_last, b.f, b.l, b.p);
                    end
                end
            end
            checks++;
            if (ready !== final_prev) begin
                fails++;
                $display("FAIL %s ready_pulse cycle %0d: got %b expected %b", name, cyc, ready, final_prev);
            end
            if (final_prev) begin
                checks++;
                if (cyc != c0 + 1 + n_exp + stalls || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL %s ready_timing: cycle %0d busy %b expected cycle %0d busy 1",
                             name, cyc - c0, busy, 1 + n_exp + stalls);
                end
            end
            if (abort_prev) begin
                checks++;
                if ({out_valid, busy} !== 2'b00) begin
                    fails++;
                    $display("FAIL %s abort_idle: valid/busy got %b%b expected 00", name, out_valid, busy);
                end
            end
            if (ready_prev) begin
                checks++;
                if (busy !== 1'b0 || out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL %s busy_fall: busy %b valid %b expected 0 0", name, busy, out_valid);
                end
                done = 1;
            end
            if (aborted && !abort) begin
                post_abort++;
                if (post_abort >= 4) done = 1;
            end
            hs = out_valid && out_ready && !abort;
            if (out_valid && !out_ready && !abort) stalls++;
            final_prev = hs && (idx == n_exp - 1);
            abort_prev = abort;
            ready_prev = ready;
            if (hs) idx++;
            @(posedge clk); #1;
            abort = 1'b0;
            go = 1'b0;
        end
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL %s timeout: run did not complete within cycle budget", name);
        end
        checks++;
        if (idx != (aborted ? abort_at : n_exp)) begin
            fails++;
            $display("FAIL %s beat_count: got %0d expected %0d", name, idx, aborted ? abort_at : n_exp);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, first_data, last_data, plane_last, busy, ready, cena} !== 7'b0000001 ||
            aa_data !== 12'd0) begin
            fails++;
            $display("FAIL reset_values: v%b f%b l%b p%b busy%b rdy%b cena%b addr%0d expected all 0, cena 1",
                     out_valid, first_data, last_data, plane_last, busy, ready, cena, aa_data);
        end
        checks++;
        if ({out_valid_b, busy_b, cena_b} !== 3'b001) begin
            fails++;
            $display("FAIL reset_values_b: valid %b busy %b cena %b expected 0 0 1", out_valid_b, busy_b, cena_b);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({out_valid, busy} !== 2'b00) begin
                fails++;
                $display("FAIL idle_after_reset: valid/busy got %b%b expected 00", out_valid, busy);
            end
        end
    endtask

    task automatic test_go_ignored();
        @(posedge clk); #1;
        go = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        go = 1'b0; abort = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({out_valid, busy} !== 2'b00) begin
                fails++;
                $display("FAIL go_with_abort: valid/busy got %b%b expected 00", out_valid, busy);
            end
        end
        run_walk("go_mid_run", 0, -1, 1'b1);
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        go = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL async_reset_busy_before: got %b expected 1", busy);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({out_valid, first_data, last_data, plane_last, busy, ready, cena} !== 7'b0000001 ||
            aa_data !== 12'd0) begin
            fails++;
            $display("FAIL async_reset: v%b f%b l%b p%b busy%b rdy%b cena%b addr%0d expected all 0, cena 1",
                     out_valid, first_data, last_data, plane_last, busy, ready, cena, aa_data);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({out_valid, busy} !== 2'b00) begin
                fails++;
                $display("FAIL idle_after_async_reset: valid/busy got %b%b expected 00", out_valid, busy);
            end
        end
        run_walk("post_reset", 0, -1, 1'b0);
    endtask

    task automatic test_overlap();
        int idx, n_exp;
        bit got_ready;
        beat_t b;
        idx = 0; got_ready = 0; n_exp = n_beats(cfg_b);
        @(posedge clk); #1;
        go_b = 1'b1;
        @(posedge clk); #1;
        go_b = 1'b0;
        for (int i = 0; i < 400 && !got_ready; i++) begin
            ready_in_b = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid_b && ready_in_b) begin
                if (idx >= n_exp) begin
                    checks++; fails++;
                    $display("FAIL overlap overrun: beat %0d beyond %0d", idx, n_exp);
                end else begin
                    b = model_beat(cfg_b, idx);
                    checks++;
                    if (aa_data_b !== 12'(b.addr)) begin
                        fails++;
                        $display("FAIL overlap addr beat %0d: got %0d expected %0d", idx, aa_data_b, b.addr);
                    end
                    checks++;
                    if ({first_b, last_b, plane_last_b} !== {b.f, b.l, b.p}) begin
                        fails++;
                        $display("FAIL overlap flags beat %0d: got %b%b%b expected %b%b%b", idx,
                                 first_b, last_b, plane_last_b, b.f, b.l, b.p);
                    end
                end
                idx++;
            end
            if (ready_b) got_ready = 1;
            @(posedge clk); #1;
        end
        ready_in_b = 1'b1;
        checks++;
        if (!got_ready || idx != n_exp) begin
            fails++;
            $display("FAIL overlap_count: ready %b beats %0d expected ready 1 beats %0d", got_ready, idx, n_exp);
        end
    endtask

    task automatic test_basic_walk();
        run_walk("basic", 0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_walk("stall", 1, -1, 1'b0);
    endtask

    task automatic test_random_ready();
        run_walk("random_a", 2, -1, 1'b0);
        run_walk("random_b", 2, -1, 1'b0);
    endtask

    task automatic test_abort();
        run_walk("abort", 0, 10, 1'b0);
        run_walk("after_abort", 0, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_walk("b2b_first", 0, -1, 1'b0);
        run_walk("b2b_second", 2, -1, 1'b0);
    endtask

    initial begin
        cfg_a = '{c: 2, kx: 2, ky: 2, sx: 2, sy: 2, w: 4, h: 4};
        cfg_b = '{c: 1, kx: 3, ky: 3, sx: 1, sy: 1, w: 5, h: 5};
        rstn = 1'b0; go = 1'b0; abort = 1'b0; out_ready = 1'b1;
        go_b = 1'b0; abort_b = 1'b0; ready_in_b = 1'b1;
        test_reset();
        test_basic_walk();
        test_backpressure();
        test_random_ready();
        test_abort();
        test_go_ignored();
        test_back_to_back();
        test_overlap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
